// File: rtl/assist_sched.sv
// assist_sched: rider target scale -> effective torque scale.
// Effective scale ramps one unit per RAMP_CYC cycles; brake forces zero and
// holds it for HOLD_CYC cycles after release.
// Build option: ASSIST_RAMP_EN. When undefined, the ramp is removed and the
// effective scale follows the target one edge later.
module assist_sched #(
    parameter int unsigned RAMP_CYC = 50000,
    parameter int unsigned HOLD_CYC = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] scale_tgt,
    input  logic       brake_n,
    output logic [2:0] scale_eff,
    output logic       scale_vld,
    output logic       ramping,
    output logic       braked
);

    localparam int unsigned HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC);

`ifdef ASSIST_RAMP_EN
    localparam int unsigned SW = $clog2(RAMP_CYC);
    localparam logic [SW-1:0] STEP_LAST = SW'(RAMP_CYC - 1);
`endif

    typedef enum logic [1:0] {StHold, StRampUp, StRampDown, StBraked} state_e;

    state_e          state_q, state_d;
    logic [2:0]      eff_q, eff_d;
    logic            vld_q, vld_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
`ifdef ASSIST_RAMP_EN
    logic [SW-1:0]   step_cnt_q, step_cnt_d;
`endif

    // Next-state logic; brake overrides every state and input.
    always_comb begin
        state_d    = state_q;
        eff_d      = eff_q;
        vld_d      = 1'b0;
        hold_cnt_d = '0;
`ifdef ASSIST_RAMP_EN
        step_cnt_d = step_cnt_q;
`endif
        if (!brake_n) begin
            state_d = StBraked;
            eff_d   = 3'd0;
            vld_d   = (eff_q != 3'd0);
`ifdef ASSIST_RAMP_EN
            // Drop any partially counted step.
            step_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                StHold: begin
`ifdef ASSIST_RAMP_EN
                    if (scale_tgt > eff_q) begin
                        state_d    = StRampUp;
                        step_cnt_d = '0;
                    end else if (scale_tgt < eff_q) begin
                        state_d    = StRampDown;
                        step_cnt_d = '0;
                    end
`else
                    if (scale_tgt != eff_q) begin
                        eff_d = scale_tgt;
                        vld_d = 1'b1;
                    end
`endif
                end
`ifdef ASSIST_RAMP_EN
                StRampUp: begin
                    if (scale_tgt == eff_q) begin
                        state_d    = StHold;
                        step_cnt_d = '0;
                    end else if (scale_tgt < eff_q) begin
                        state_d    = StRampDown;
                        step_cnt_d = '0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        // tgt > eff here, so +1 can neither overshoot nor wrap.
                        eff_d      = eff_q + 3'd1;
                        vld_d      = 1'b1;
                        step_cnt_d = '0;
                        if (eff_d == scale_tgt) state_d = StHold;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
                StRampDown: begin
                    if (scale_tgt == eff_q) begin
                        state_d    = StHold;
                        step_cnt_d = '0;
                    end else if (scale_tgt > eff_q) begin
                        state_d    = StRampUp;
                        step_cnt_d = '0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        eff_d      = eff_q - 3'd1;
                        vld_d      = 1'b1;
                        step_cnt_d = '0;
                        if (eff_d == scale_tgt) state_d = StHold;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
`endif
                StBraked: begin
                    eff_d      = 3'd0;
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_d == HOLD_LAST) state_d = StHold;
                end
                default: state_d = StHold;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StHold;
            eff_q      <= 3'd0;
            vld_q      <= 1'b0;
            hold_cnt_q <= '0;
`ifdef ASSIST_RAMP_EN
            step_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            eff_q      <= eff_d;
            vld_q      <= vld_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef ASSIST_RAMP_EN
            step_cnt_q <= step_cnt_d;
`endif
        end
    end

    // Outputs decode directly from registered state.
    always_comb begin
        scale_eff = eff_q;
        scale_vld = vld_q;
        braked    = (state_q == StBraked);
`ifdef ASSIST_RAMP_EN
        ramping   = (state_q == StRampUp) || (state_q == StRampDown);
`else
        ramping   = 1'b0;
`endif
    end

endmodule

// File: doc/assist_sched.md
# assist_sched

Assist-level scheduler between the push-button mode interface and the motor torque path. Takes the rider-selected target scale (3-bit) and drives the effective scale the torque math uses. Effective scale ramps one unit per step interval, so mode presses and brake recovery never produce an abrupt torque jump. Brake requests force zero assist immediately, then hold it at zero for a programmable holdoff.

## Interface
Parameters:
- RAMP_CYC, 50000: clock cycles per one-unit ramp step (1 ms @ 50 MHz); minimum 2.
- HOLD_CYC, 25000000: cycles of zero assist after brake release (0.5 s); minimum 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- scale_tgt  in  3  target scale from the mode interface; synchronous, may change on any cycle.
- brake_n  in  1  active-low brake request, already synchronized to clk.
- scale_eff  out  3  registered effective scale to the torque path.
- scale_vld  out  1  one-cycle pulse on the cycle scale_eff takes a new value.
- ramping  out  1  high in RAMP_UP / RAMP_DOWN.
- braked  out  1  high in BRAKED.

## Operation
- States: HOLD, RAMP_UP, RAMP_DOWN, BRAKED.
- Internal counters:
  - step counter: $clog2(RAMP_CYC) bits.
  - holdoff counter: $clog2(HOLD_CYC+1) bits.
- Priority: brake_n low overrides every state and every other input on the same edge.
- HOLD:
  - tgt > eff -> RAMP_UP, step counter cleared.
  - tgt < eff -> RAMP_DOWN, step counter cleared.
  - tgt == eff -> stay.
- RAMP_UP / RAMP_DOWN:
  - Step counter increments each cycle.
  - At count RAMP_CYC-1: eff moves ±1 toward tgt, counter clears, scale_vld pulses.
  - After the step, eff == tgt -> HOLD; otherwise stay.
- Target change mid-ramp:
  - tgt == eff -> HOLD next edge, no step.
  - tgt on the opposite side of eff -> switch ramp direction next edge, counter cleared.
  - tgt moves further in the same direction -> counter not cleared.
- Arithmetic: eff never leaves 0..7. A step never overshoots tgt, and there is no wrap-around.
- BRAKED:
  - eff is 0; holdoff counter cleared while brake_n is low.
  - Once brake_n is high, the counter counts up.
  - Reaching HOLD_CYC -> HOLD, which then ramps from 0 toward tgt.
  - brake_n low again during holdoff -> counter cleared, restart from zero.
- Entering BRAKED with eff already 0: no scale_vld pulse.

## Timing
- Reset values:
  - state HOLD, scale_eff 0.
  - scale_vld 0, ramping 0, braked 0.
  - both counters 0.
- After reset, the PB default tgt of 5 produces a soft start: 0 -> 5 over 5·RAMP_CYC cycles plus one HOLD->RAMP_UP cycle.
- Brake latency: brake_n sampled low at edge k gives scale_eff = 0 and braked = 1 after edge k. scale_vld is high for the cycle following k if eff was nonzero.
- Ramp step latency: first step lands RAMP_CYC edges after entering the RAMP state. scale_vld is coincident with the new scale_eff value.
- Brake release to first possible step: HOLD_CYC + 1 + RAMP_CYC edges.
- Reset asserted mid-ramp or mid-holdoff: immediate return to reset values; no pending step completes.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- ASSIST_RAMP_EN defined: full ramp behaviour as above.
- ASSIST_RAMP_EN undefined:
  - RAMP_UP / RAMP_DOWN are never entered and the step counter is removed.
  - In HOLD, eff loads tgt on the next edge, with scale_vld when the value changes.
  - ramping is tied 0.
  - Brake and holdoff behaviour are unchanged; after holdoff, eff jumps to tgt one edge after entering HOLD.

## Test plan
- Reset ramp (RAMP_CYC=4, tgt=5 held):
  - scale_eff steps 1,2,3,4,5 at edges 5,9,13,17,21 after reset release.
  - Five scale_vld pulses; ramping drops with the final step.
- Down-ramp then reversal (RAMP_CYC=4):
  - From eff=7, set tgt=0; after eff reaches 5, set tgt=7.
  - Direction flips with counter cleared; eff reaches 7 four edges per step later; no overshoot.
- Brake mid-ramp (eff=3, HOLD_CYC=10):
  - Drop brake_n for 3 cycles -> eff=0 and braked=1 after the first edge.
  - eff stays 0 for 10 cycles after release, then ramps back to tgt.
- Re-brake during holdoff: pulse brake_n low at holdoff count 6 -> counter restarts; exit occurs 10 cycles after the second release.
- Reset mid-ramp (eff=2 rising toward 7): assert rst_n low -> all outputs 0 immediately; ramp restarts from 0 after release.
- ASSIST_RAMP_EN undefined: tgt 2 -> 6 -> eff=6 one edge later with one scale_vld pulse; ramping never asserts.
